// File: rtl/irq_ctrl.sv
// Edge-capturing interrupt controller with mask/pending registers on an 8-bit Wishbone slave.
// Raises one priority-encoded level request to the CPU and holds it until the synchronised Iack.
module irq_ctrl #(
  parameter int NUM_SRC     = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk_50mhz,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_src_i,
  input  logic [1:0]         wb_adr_i,
  input  logic [7:0]         wb_dat_i,
  output logic [7:0]         wb_dat_o,
  input  logic               wb_stb_i,
  input  logic               wb_we_i,
  output logic               wb_ack_o,
  output logic               Ireq_o,
  input  logic               Iack_i,
  output logic [2:0]         irq_id_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_LOW} state_t;

  localparam logic [7:0] SRC_BITS = 8'((9'd1 << NUM_SRC) - 9'd1);

  state_t                              state, state_nxt;
  logic [SYNC_STAGES-1:0][NUM_SRC-1:0] src_sync;
  logic [NUM_SRC-1:0]                  src_d;
  logic [SYNC_STAGES-1:0]              iack_sync;
  logic                                iack_s;
  logic [7:0]                          pend, pend_nxt, mask, act, edges, rd_dat;
  logic                                wr_en, ireq_nxt, win_vld;
  logic [2:0]                          id_nxt, win_id;

  assign iack_s = iack_sync[SYNC_STAGES-1];
  assign edges  = 8'(src_sync[SYNC_STAGES-1] & ~src_d);
  assign act    = pend & mask;
  // Writes land on the same edge that raises the ack.
  assign wr_en  = wb_stb_i & wb_we_i & ~wb_ack_o;

  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst) begin
      src_sync  <= '0;
      src_d     <= '0;
      iack_sync <= '0;
    end else begin
      src_sync[0]  <= irq_src_i;
      iack_sync[0] <= Iack_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        src_sync[i]  <= src_sync[i-1];
        iack_sync[i] <= iack_sync[i-1];
      end
      src_d <= src_sync[SYNC_STAGES-1];
    end
  end

  // Edge OR is applied last so a fresh edge survives a same-cycle clear.
  always_comb begin
    pend_nxt = pend;
    if (wr_en && wb_adr_i == 2'd0)
      pend_nxt = pend_nxt & ~wb_dat_i;
    if (state == REQ && iack_s)
      pend_nxt[irq_id_o] = 1'b0;
    pend_nxt = (pend_nxt | edges) & SRC_BITS;
  end

  always_comb begin
    win_vld = 1'b0;
    win_id  = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (act[i]) begin
        win_vld = 1'b1;
        win_id  = 3'(i);
      end
    end
  end

  always_comb begin
    rd_dat = 8'h00;
    case (wb_adr_i)
      2'd0:    rd_dat = pend;
      2'd1:    rd_dat = mask;
      2'd2:    rd_dat = {Ireq_o, 4'b0000, irq_id_o};
      default: rd_dat = 8'h00;
    endcase
  end

  always_comb begin
    state_nxt = state;
    ireq_nxt  = Ireq_o;
    id_nxt    = irq_id_o;
    case (state)
      IDLE: begin
        if (win_vld) begin
          id_nxt    = win_id;
          ireq_nxt  = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (iack_s) begin
          ireq_nxt  = 1'b0;
          state_nxt = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        if (!iack_s)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      Ireq_o   <= 1'b0;
      irq_id_o <= 3'd0;
      pend     <= '0;
      mask     <= '0;
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      state    <= state_nxt;
      Ireq_o   <= ireq_nxt;
      irq_id_o <= id_nxt;
      pend     <= pend_nxt;
      wb_ack_o <= wb_stb_i & ~wb_ack_o;
      if (wb_stb_i && !wb_ack_o)
        wb_dat_o <= rd_dat;
      if (wr_en && wb_adr_i == 2'd1)
        mask <= wb_dat_i & SRC_BITS;
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: register-access vector table plus hand-written interrupt sequences.
module tb_irq_ctrl;

  localparam int NUM_SRC     = 4;
  localparam int SYNC_STAGES = 2;

  logic         clk_50mhz = 1'b0;
  logic         rst       = 1'b1;
  logic [3:0]   irq_src_i = '0;
  logic [1:0]   wb_adr_i  = '0;
  logic [7:0]   wb_dat_i  = '0;
  logic [7:0]   wb_dat_o;
  logic         wb_stb_i  = 1'b0;
  logic         wb_we_i   = 1'b0;
  logic         wb_ack_o;
  logic         Ireq_o;
  logic         Iack_i    = 1'b0;
  logic [2:0]   irq_id_o;

  int n_run  = 0;
  int n_fail = 0;

  irq_ctrl #(.NUM_SRC(NUM_SRC), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk_50mhz (clk_50mhz),
    .rst       (rst),
    .irq_src_i (irq_src_i),
    .wb_adr_i  (wb_adr_i),
    .wb_dat_i  (wb_dat_i),
    .wb_dat_o  (wb_dat_o),
    .wb_stb_i  (wb_stb_i),
    .wb_we_i   (wb_we_i),
    .wb_ack_o  (wb_ack_o),
    .Ireq_o    (Ireq_o),
    .Iack_i    (Iack_i),
    .irq_id_o  (irq_id_o)
  );

  always #10 clk_50mhz = ~clk_50mhz;

  typedef struct {
    logic [1:0] adr;
    logic       we;
    logic [7:0] dat;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic wb_xfer(input logic [1:0] adr, input logic we, input logic [7:0] dat,
                         output logic [7:0] rd);
    @(negedge clk_50mhz);
    wb_adr_i = adr;
    wb_we_i  = we;
    wb_dat_i = dat;
    wb_stb_i = 1'b1;
    @(posedge clk_50mhz);
    #1;
    rd = wb_dat_o;
    check("wb_ack", {31'd0, wb_ack_o}, 32'd1);
    @(negedge clk_50mhz);
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
  endtask

  task automatic wait_ireq(input logic val, input int max, output int lat);
    lat = 0;
    while (Ireq_o !== val && lat < max) begin
      @(posedge clk_50mhz);
      #1;
      lat++;
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk_50mhz);
    #1;
  endtask

  initial begin
    logic [7:0] rd;
    int         lat;
    int         saw_req;

    vecs[0]  = '{2'd0, 1'b0, 8'h00, 8'h00};
    vecs[1]  = '{2'd1, 1'b0, 8'h00, 8'h00};
    vecs[2]  = '{2'd2, 1'b0, 8'h00, 8'h00};
    vecs[3]  = '{2'd3, 1'b0, 8'h00, 8'h00};
    vecs[4]  = '{2'd1, 1'b1, 8'hFF, 8'h00};
    vecs[5]  = '{2'd1, 1'b0, 8'h00, 8'h0F};
    vecs[6]  = '{2'd3, 1'b1, 8'hAA, 8'h00};
    vecs[7]  = '{2'd3, 1'b0, 8'h00, 8'h00};
    vecs[8]  = '{2'd2, 1'b1, 8'h55, 8'h00};
    vecs[9]  = '{2'd2, 1'b0, 8'h00, 8'h00};
    vecs[10] = '{2'd1, 1'b1, 8'h05, 8'h00};
    vecs[11] = '{2'd1, 1'b0, 8'h00, 8'h05};

    #25;
    check("rst_ireq", {31'd0, Ireq_o}, 32'd0);
    check("rst_id", {29'd0, irq_id_o}, 32'd0);
    check("rst_ack", {31'd0, wb_ack_o}, 32'd0);
    check("rst_dat", {24'd0, wb_dat_o}, 32'd0);
    @(negedge clk_50mhz);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      wb_xfer(vecs[i].adr, vecs[i].we, vecs[i].dat, rd);
      if (!vecs[i].we)
        check($sformatf("vec%0d_rd", i), {24'd0, rd}, {24'd0, vecs[i].exp});
    end
    wb_xfer(2'd1, 1'b1, 8'h00, rd);

    // Held strobe acks on alternate cycles.
    @(negedge clk_50mhz);
    wb_adr_i = 2'd3; wb_we_i = 1'b0; wb_stb_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_50mhz);
      #1;
      check($sformatf("held_stb_ack%0d", i), {31'd0, wb_ack_o}, (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    @(negedge clk_50mhz);
    wb_stb_i = 1'b0;
    cycles(2);

    // Single source, 3-cycle pulse.
    wb_xfer(2'd1, 1'b1, 8'h01, rd);
    @(negedge clk_50mhz);
    irq_src_i[0] = 1'b1;
    lat = 0;
    while (Ireq_o !== 1'b1 && lat < 10) begin
      @(posedge clk_50mhz);
      #1;
      lat++;
      if (lat == 3) irq_src_i[0] = 1'b0;
    end
    irq_src_i[0] = 1'b0;
    check("req0_ireq", {31'd0, Ireq_o}, 32'd1);
    check("req0_latency_le", {31'd0, lat <= SYNC_STAGES + 2}, 32'd1);
    check("req0_id", {29'd0, irq_id_o}, 32'd0);
    wb_xfer(2'd0, 1'b0, 8'h00, rd);
    check("req0_pending", {24'd0, rd}, 32'h01);
    wb_xfer(2'd2, 1'b0, 8'h00, rd);
    check("req0_cause", {24'd0, rd}, 32'h80);

    // Ack, then long Iack with a new edge arriving: must wait for Iack low.
    @(negedge clk_50mhz);
    Iack_i = 1'b1;
    wait_ireq(1'b0, 10, lat);
    check("ack0_ireq", {31'd0, Ireq_o}, 32'd0);
    wb_xfer(2'd0, 1'b0, 8'h00, rd);
    check("ack0_pending", {24'd0, rd}, 32'h00);
    saw_req = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk_50mhz);
      #1;
      if (i == 10) irq_src_i[0] = 1'b1;
      if (i == 14) irq_src_i[0] = 1'b0;
      if (Ireq_o) saw_req++;
    end
    check("long_iack_no_req", saw_req, 0);
    wb_xfer(2'd0, 1'b0, 8'h00, rd);
    check("long_iack_pending", {24'd0, rd}, 32'h01);
    @(negedge clk_50mhz);
    Iack_i = 1'b0;
    wait_ireq(1'b1, 10, lat);
    check("b2b_ireq", {31'd0, Ireq_o}, 32'd1);
    check("b2b_id", {29'd0, irq_id_o}, 32'd0);
    Iack_i = 1'b1;
    wait_ireq(1'b0, 10, lat);
    Iack_i = 1'b0;
    cycles(5);

    // Simultaneous sources 1 and 2: priority order.
    wb_xfer(2'd1, 1'b1, 8'h0F, rd);
    @(negedge clk_50mhz);
    irq_src_i = 4'b0110;
    wait_ireq(1'b1, 10, lat);
    check("prio_ireq", {31'd0, Ireq_o}, 32'd1);
    check("prio_first_id", {29'd0, irq_id_o}, 32'd1);
    Iack_i = 1'b1;
    wait_ireq(1'b0, 10, lat);
    Iack_i = 1'b0;
    wait_ireq(1'b1, 10, lat);
    check("prio_second_ireq", {31'd0, Ireq_o}, 32'd1);
    check("prio_second_id", {29'd0, irq_id_o}, 32'd2);
    Iack_i = 1'b1;
    wait_ireq(1'b0, 10, lat);
    Iack_i = 1'b0;
    irq_src_i = 4'b0000;
    cycles(6);

    // Masked source: pending but no request; W1C; then unmasking does nothing.
    wb_xfer(2'd1, 1'b1, 8'h00, rd);
    @(negedge clk_50mhz);
    irq_src_i[3] = 1'b1;
    cycles(6);
    check("masked_ireq", {31'd0, Ireq_o}, 32'd0);
    wb_xfer(2'd0, 1'b0, 8'h00, rd);
    check("masked_pending", {24'd0, rd}, 32'h08);
    wb_xfer(2'd0, 1'b1, 8'h08, rd);
    wb_xfer(2'd0, 1'b0, 8'h00, rd);
    check("w1c_pending", {24'd0, rd}, 32'h00);
    wb_xfer(2'd1, 1'b1, 8'h08, rd);
    cycles(6);
    check("unmask_no_req", {31'd0, Ireq_o}, 32'd0);
    irq_src_i[3] = 1'b0;

    // Held level gives exactly one request.
    wb_xfer(2'd1, 1'b1, 8'h02, rd);
    @(negedge clk_50mhz);
    irq_src_i[1] = 1'b1;
    wait_ireq(1'b1, 10, lat);
    check("level_ireq", {31'd0, Ireq_o}, 32'd1);
    check("level_id", {29'd0, irq_id_o}, 32'd1);
    Iack_i = 1'b1;
    wait_ireq(1'b0, 10, lat);
    Iack_i = 1'b0;
    saw_req = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk_50mhz);
      #1;
      if (Ireq_o) saw_req++;
    end
    check("level_single_req", saw_req, 0);
    @(negedge clk_50mhz);
    irq_src_i[1] = 1'b0;
    cycles(5);

    // Fresh edge lands on the same edge as a W1C of that bit.
    @(negedge clk_50mhz);
    irq_src_i[1] = 1'b1;
    @(posedge clk_50mhz);
    @(posedge clk_50mhz);
    @(negedge clk_50mhz);
    wb_adr_i = 2'd0; wb_we_i = 1'b1; wb_dat_i = 8'h02; wb_stb_i = 1'b1;
    @(posedge clk_50mhz);
    @(negedge clk_50mhz);
    wb_stb_i = 1'b0; wb_we_i = 1'b0;
    wb_xfer(2'd0, 1'b0, 8'h00, rd);
    check("edge_beats_w1c", {24'd0, rd}, 32'h02);
    wait_ireq(1'b1, 10, lat);
    check("edge_beats_w1c_ireq", {31'd0, Ireq_o}, 32'd1);

    // Asynchronous reset while a request is outstanding.
    @(negedge clk_50mhz);
    #3;
    rst = 1'b1;
    irq_src_i = 4'b0000;
    #1;
    check("arst_ireq", {31'd0, Ireq_o}, 32'd0);
    check("arst_ack", {31'd0, wb_ack_o}, 32'd0);
    check("arst_id", {29'd0, irq_id_o}, 32'd0);
    cycles(2);
    @(negedge clk_50mhz);
    rst = 1'b0;
    wb_xfer(2'd1, 1'b0, 8'h00, rd);
    check("arst_mask", {24'd0, rd}, 32'h00);
    wb_xfer(2'd0, 1'b0, 8'h00, rd);
    check("arst_pending", {24'd0, rd}, 32'h00);
    cycles(10);
    check("arst_no_req", {31'd0, Ireq_o}, 32'd0);
    wb_xfer(2'd1, 1'b1, 8'h02, rd);
    @(negedge clk_50mhz);
    irq_src_i[1] = 1'b1;
    wait_ireq(1'b1, 10, lat);
    check("post_rst_ireq", {31'd0, Ireq_o}, 32'd1);
    check("post_rst_id", {29'd0, irq_id_o}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
